// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: PC generation, in-order imem requests, response FIFO, redirect flush.
// Optional FETCH_BYPASS_EN: empty-FIFO responses go straight to the output in the arrival cycle.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = $clog2(DEPTH) + 1;
    localparam logic [63:0] BUBBLE = 64'h0000_0013_0000_0000;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [63:0]   fifo_mem [DEPTH];
    logic [31:0]   tag_mem  [DEPTH];

    logic          fire_req, rsp_ok, push, pop, bypass;
    logic [CW:0]   credit_used;
    logic [31:0]   rsp_pc;
    logic          redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Issue, response acceptance and output presentation.
    always_comb begin
        credit_used = {1'b0, outst_q} + {1'b0, count_q};
        imem_req    = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
        imem_addr   = pc_q;
        fire_req    = imem_req && imem_gnt;
        rsp_ok      = imem_rvalid && (outst_q != '0);
        rsp_pc      = tag_mem[tag_rd_q];
`ifdef FETCH_BYPASS_EN
        bypass      = rsp_ok && (count_q == '0) && (drop_q == '0) && !redirect_valid
                      && out_ready && !reset;
`else
        bypass      = 1'b0;
`endif
        push        = rsp_ok && (drop_q == '0) && !redirect_valid && !bypass;
        out_valid   = !reset && !redirect_valid && ((count_q != '0) || bypass);
        pop         = out_valid && out_ready && !bypass;
        out_data    = BUBBLE;
        if (bypass) begin
            out_data = {imem_rdata, rsp_pc};
        end else if (out_valid) begin
            out_data = fifo_mem[rd_ptr_q];
        end
    end

    // Next-state for PC, credit counters and queue pointers.
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        outst_d  = outst_q + CW'(fire_req) - CW'(rsp_ok);
        drop_d   = drop_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        tag_wr_d = tag_wr_q + AW'(fire_req);
        tag_rd_d = tag_rd_q + AW'(rsp_ok);
        if (rsp_ok && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (fire_req) begin
            pc_d = pc_q + 32'd4;
        end
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d     = {redirect_pc[31:2], 2'b00};
            drop_d   = outst_q - CW'(rsp_ok);
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
        end
    end

    // Storage arrays need no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {imem_rdata, rsp_pc};
        end
        if (fire_req) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a queue-based memory model and packet scoreboard.
module tb_if_fetch_queue;

`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif
    localparam logic [63:0] BUBBLE = 64'h0000_0013_0000_0000;
    localparam logic [31:0] XORK   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [63:0] out_data;

    logic        hi_req, hi_ov, hi_gnt, hi_rvalid, hi_redir, hi_ready;
    logic [31:0] hi_addr, hi_rdata, hi_rpc;
    logic [63:0] hi_od;

    int          n_asserts = 0;
    int          n_fail    = 0;
    int          n_pkts    = 0;
    logic        got_first = 1'b0;
    logic [31:0] first_pc  = 32'h0;
    logic        mem_en    = 1'b1;
    logic [63:0] exp_q [$];
    logic [31:0] mem_q [$];

    always #5 clk = ~clk;

    if_fetch_queue u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    if_fetch_queue #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
        .clk(clk), .reset(reset),
        .imem_req(hi_req), .imem_addr(hi_addr), .imem_gnt(hi_gnt),
        .imem_rvalid(hi_rvalid), .imem_rdata(hi_rdata),
        .redirect_valid(hi_redir), .redirect_pc(hi_rpc),
        .out_valid(hi_ov), .out_ready(hi_ready), .out_data(hi_od)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        n_pkts    = 0;
        got_first = 1'b0;
    endtask

    // One clock: score outputs mid-cycle, then advance the memory model after the edge.
    task automatic tick();
        logic        req_s, gnt_s, pop_s, rst_s, redir_s;
        logic [31:0] addr_s, a;
        logic [63:0] data_s, e;
        #1;
        req_s   = imem_req;
        gnt_s   = imem_gnt;
        addr_s  = imem_addr;
        pop_s   = out_valid && out_ready;
        data_s  = out_data;
        rst_s   = reset;
        redir_s = redirect_valid;
        if (pop_s) begin
            if (exp_q.size() == 0) begin
                chk("pkt_unexpected", data_s, BUBBLE);
            end else begin
                e = exp_q.pop_front();
                chk("pkt", data_s, e);
            end
            if (!got_first) begin
                first_pc  = data_s[31:0];
                got_first = 1'b1;
            end
            n_pkts++;
        end
        if (rst_s || redir_s) exp_q.delete();
        if (req_s && gnt_s && !rst_s) exp_q.push_back({addr_s ^ XORK, addr_s});
        @(posedge clk);
        #1;
        if (rst_s) begin
            mem_q.delete();
            imem_rvalid = 1'b0;
        end else begin
            if (req_s && gnt_s) mem_q.push_back(addr_s);
            if (mem_en && mem_q.size() > 0) begin
                a           = mem_q.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = a ^ XORK;
            end else begin
                imem_rvalid = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        mem_en = 1'b1;
        #1;
        chk("rst_req", 64'(imem_req), 64'(1'b0));
        chk("rst_ov", 64'(out_valid), 64'(1'b0));
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_addr", 64'(imem_addr), 64'(32'h0));
        chk("post_rst_ov", 64'(out_valid), 64'(1'b0));
        chk("post_rst_bubble", out_data, BUBBLE);
        mark();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        hi_gnt = 1'b1; hi_rvalid = 1'b0; hi_rdata = 32'h0;
        hi_redir = 1'b0; hi_rpc = 32'h0; hi_ready = 1'b1;

        // Streaming with 1-cycle memory, plus high RESET_PC wrap on the second instance.
        tick();
        do_reset();
        chk("hi_addr0", 64'(hi_addr), 64'(32'hFFFF_FFF8));
        tick();
        #1;
        chk("rsp_cycle_ov", 64'(out_valid), 64'(BYP));
        chk("hi_addr1", 64'(hi_addr), 64'(32'hFFFF_FFFC));
        tick();
        #1;
        chk("hi_addr2", 64'(hi_addr), 64'(32'h0000_0000));
        chk("hi_req_full", 64'(hi_req), 64'(1'b0));
        for (int i = 0; i < 30; i++) tick();
        chk("s1_first_pc", 64'(first_pc), 64'(32'h0));
        chk("s1_pkt_count", 64'(n_pkts >= 16), 64'(1'b1));

        // Stall: credits exhaust with PCs 0 and 4 buffered, then drain in order.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        #1;
        chk("stall_req", 64'(imem_req), 64'(1'b0));
        chk("stall_ov", 64'(out_valid), 64'(1'b1));
        chk("stall_head", out_data, {XORK, 32'h0});
        out_ready = 1'b1;
        tick();
        #1;
        chk("stall_next", out_data, {XORK ^ 32'h4, 32'h4});
        for (int i = 0; i < 10; i++) tick();
        chk("s2_first_pc", 64'(first_pc), 64'(32'h0));
        chk("s2_pkt_count", 64'(n_pkts >= 3), 64'(1'b1));

        // Redirect with two fetches outstanding.
        do_reset();
        mem_en = 1'b0;
        tick();
        tick();
        #1;
        chk("two_out_req", 64'(imem_req), 64'(1'b0));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        chk("redir_ov", 64'(out_valid), 64'(1'b0));
        chk("redir_req", 64'(imem_req), 64'(1'b0));
        tick();
        redirect_valid = 1'b0;
        mem_en = 1'b1;
        mark();
        #1;
        chk("redir_addr", 64'(imem_addr), 64'(32'h0000_0100));
        for (int i = 0; i < 14; i++) tick();
        chk("s3_got_pkt", 64'(got_first), 64'(1'b1));
        chk("s3_first_pc", 64'(first_pc), 64'(32'h0000_0100));

        // Redirect coinciding with rvalid and a poppable packet.
        do_reset();
        tick();
        tick();
        #1;
        chk("pre_redir_ov", 64'(out_valid), 64'(1'b1));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        chk("same_redir_ov", 64'(out_valid), 64'(1'b0));
        tick();
        redirect_valid = 1'b0;
        mark();
        #1;
        chk("same_redir_addr", 64'(imem_addr), 64'(32'h0000_0200));
        chk("same_redir_ov_after", 64'(out_valid), 64'(1'b0));
        for (int i = 0; i < 10; i++) tick();
        chk("s4_first_pc", 64'(first_pc), 64'(32'h0000_0200));

        // Reset with the FIFO full.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        #1;
        chk("full_ov", 64'(out_valid), 64'(1'b1));
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("s5_first_pc", 64'(first_pc), 64'(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
